// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention-core stream adapter.
package attn_pkg;

    localparam int ATTN_DATA_WIDTH = 16;
    localparam int ATTN_L          = 8;
    localparam int ATTN_E          = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } adapter_state_t;

    // Element e of token tok lives at this index of the flattened row-major (L, E) matrix.
    function automatic int unsigned token_elem_idx(input int unsigned tok, input int unsigned e,
                                                   input int unsigned e_dim);
        return tok * e_dim + e;
    endfunction

endpackage

// File: rtl/attn_watchdog.sv
// Cycle watchdog: clear restarts the count, enable advances it, expire flags the final allowed cycle.
module attn_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expire = enable && (wd_cnt == LAST_CNT);

endmodule

// File: rtl/attn_stream_adapter.sv
// Streams a token frame into the attention core, kicks it, waits for done, and streams the result back out.
module attn_stream_adapter
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH     = ATTN_DATA_WIDTH,
    parameter int L              = ATTN_L,
    parameter int E              = ATTN_E,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH*E-1:0]     s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH*E-1:0]     m_data,
    output logic                        m_last,
    output logic                        attn_start,
    input  logic                        attn_done,
    output logic [DATA_WIDTH-1:0]       attn_x [L*E],
    input  logic [DATA_WIDTH-1:0]       attn_out [L*E],
    output logic                        busy,
    output logic                        err_timeout,
    output logic                        err_framing,
    input  logic                        err_clr,
    output logic [FRAME_CNT_W-1:0]      frame_cnt,
    output adapter_state_t              state_dbg
);

    localparam int TOK_W = (L > 1) ? $clog2(L) : 1;
    localparam logic [TOK_W-1:0] LAST_TOK = TOK_W'(L - 1);

    adapter_state_t        state;
    logic [TOK_W-1:0]      tok_cnt;
    logic [DATA_WIDTH-1:0] x_buf   [L*E];
    logic [DATA_WIDTH-1:0] out_buf [L*E];
    logic                  last_tok;
    logic                  load_fire;
    logic                  drain_fire;
    logic                  wd_expire;
    logic                  timeout_hit;

    // Handshake outputs are pure decodes of the state register, so they are glitch-free and 0 in reset.
    assign s_ready     = (state == S_LOAD);
    assign m_valid     = (state == S_DRAIN);
    assign attn_start  = (state == S_START);
    assign busy        = (state == S_START) || (state == S_WAIT) || (state == S_DRAIN);
    assign last_tok    = (tok_cnt == LAST_TOK);
    assign m_last      = m_valid && last_tok;
    assign load_fire   = s_valid && s_ready;
    assign drain_fire  = m_valid && m_ready;
    assign timeout_hit = wd_expire && !attn_done;
    assign state_dbg   = state;
    assign attn_x      = x_buf;

    attn_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state == S_START),
        .enable(state == S_WAIT),
        .expire(wd_expire)
    );

    always_comb begin
        m_data = '0;
        for (int r = 0; r < L; r++) begin
            if (tok_cnt == TOK_W'(r)) begin
                for (int e = 0; e < E; e++) begin
                    m_data[e*DATA_WIDTH +: DATA_WIDTH] = out_buf[token_elem_idx(r, e, E)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tok_cnt     <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            err_framing <= 1'b0;
            for (int i = 0; i < L*E; i++) begin
                x_buf[i]   <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            // A new error in the same cycle as err_clr keeps the flag set.
            if (load_fire && (s_last != last_tok)) begin
                err_framing <= 1'b1;
            end else if (err_clr) begin
                err_framing <= 1'b0;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (state)
                S_IDLE: state <= S_LOAD;
                S_LOAD: begin
                    if (load_fire) begin
                        for (int r = 0; r < L; r++) begin
                            if (tok_cnt == TOK_W'(r)) begin
                                for (int e = 0; e < E; e++) begin
                                    x_buf[token_elem_idx(r, e, E)] <= s_data[e*DATA_WIDTH +: DATA_WIDTH];
                                end
                            end
                        end
                        // Frame length is fixed at L beats; s_last only feeds the framing check.
                        if (last_tok) begin
                            tok_cnt <= '0;
                            state   <= S_START;
                        end else begin
                            tok_cnt <= tok_cnt + 1'b1;
                        end
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (attn_done) begin
                        for (int i = 0; i < L*E; i++) begin
                            out_buf[i] <= attn_out[i];
                        end
                        state <= S_DRAIN;
                    end else if (wd_expire) begin
                        state <= S_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (drain_fire) begin
                        if (last_tok) begin
                            tok_cnt   <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            tok_cnt <= tok_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_stream_adapter.sv
// Self-checking bench for attn_stream_adapter with a delayed-done core model and an output scoreboard.
module tb_attn_stream_adapter;
    import attn_pkg::*;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int E  = 8;
    localparam int TO = 64;
    localparam int FW = 16;
    localparam int TW = DW * E;
    localparam int CW = TW + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [TW-1:0]  s_data = '0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [TW-1:0]  m_data;
    logic           m_last;
    logic           attn_start;
    logic           attn_done = 1'b0;
    logic [DW-1:0]  attn_x [L*E];
    logic [DW-1:0]  attn_out [L*E];
    logic           busy;
    logic           err_timeout;
    logic           err_framing;
    logic           err_clr = 1'b0;
    logic [FW-1:0]  frame_cnt;
    adapter_state_t state_dbg;

    logic [CW-1:0]  exp_q[$];
    int             total = 0;
    int             bad = 0;
    int             start_cnt = 0;
    logic           stalled = 1'b0;
    logic [CW-1:0]  hold_tok = '0;

    attn_stream_adapter #(
        .DATA_WIDTH(DW), .L(L), .E(E), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(FW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .attn_start(attn_start), .attn_done(attn_done), .attn_x(attn_x), .attn_out(attn_out),
        .busy(busy), .err_timeout(err_timeout), .err_framing(err_framing), .err_clr(err_clr),
        .frame_cnt(frame_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "bench did not finish");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (attn_start) start_cnt++;
            if (m_valid) begin
                if (stalled) check_eq("hold_tok", {m_last, m_data}, hold_tok);
                if (m_ready) begin
                    if (exp_q.size() == 0) check_eq("extra_tok", CW'(m_valid), CW'(0));
                    else check_eq("out_tok", {m_last, m_data}, exp_q.pop_front());
                    stalled <= 1'b0;
                end else begin
                    stalled  <= 1'b1;
                    hold_tok <= {m_last, m_data};
                end
            end else begin
                stalled <= 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int base, input logic [L-1:0] lmask, input bit push);
        logic [TW-1:0] d;
        logic [TW-1:0] x;
        int n;
        for (int t = 0; t < L; t++) begin
            for (int e = 0; e < E; e++) begin
                d[e*DW +: DW] = DW'(base + t*E + e);
                x[e*DW +: DW] = DW'(base + t*E + e + 1);
            end
            s_valid = 1'b1;
            s_data  = d;
            s_last  = lmask[t];
            if (push) exp_q.push_back({(t == L-1), x});
            n = 0;
            while (!s_ready && n < 50) begin
                step();
                n++;
            end
            if (!s_ready) check_eq("load_ready", CW'(s_ready), CW'(1));
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Core model: done arrives delay cycles after the start cycle, result = x + 1.
    task automatic respond(input int delay);
        repeat (delay) step();
        attn_done = 1'b1;
        for (int i = 0; i < L*E; i++) attn_out[i] = attn_x[i] + DW'(1);
        step();
        attn_done = 1'b0;
        check_eq("first_mvalid", CW'(m_valid), CW'(1));
    endtask

    task automatic drain(input bit toggle, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 100) begin
            m_ready = toggle ? 1'(cycles % 2) : 1'b1;
            step();
            cycles++;
        end
        m_ready = 1'b0;
        check_eq("drain_idle_mvalid", CW'(m_valid), CW'(0));
        check_eq("drain_back_ready", CW'(s_ready), CW'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc;
        int s0;
        logic seen;
        for (int i = 0; i < L*E; i++) attn_out[i] = '0;

        #1 rst = 1'b1;
        step();
        step();
        check_eq("rst_s_ready", CW'(s_ready), CW'(0));
        check_eq("rst_m_valid", CW'(m_valid), CW'(0));
        check_eq("rst_m_last", CW'(m_last), CW'(0));
        check_eq("rst_start", CW'(attn_start), CW'(0));
        check_eq("rst_busy", CW'(busy), CW'(0));
        check_eq("rst_errs", CW'({err_timeout, err_framing}), CW'(0));
        check_eq("rst_frame_cnt", CW'(frame_cnt), CW'(0));
        check_eq("rst_state", CW'(state_dbg), CW'(S_IDLE));
        check_eq("rst_x0", CW'(attn_x[0]), CW'(0));
        check_eq("rst_m_data", CW'(m_data), CW'(0));
        rst = 1'b0;
        check_eq("idle_s_ready", CW'(s_ready), CW'(0));
        step();
        check_eq("load_s_ready", CW'(s_ready), CW'(1));

        // Basic frame
        s0 = start_cnt;
        drive_frame(0, 8'h80, 1'b1);
        check_eq("basic_start", CW'(attn_start), CW'(1));
        check_eq("basic_busy", CW'(busy), CW'(1));
        respond(50);
        drain(1'b0, cyc);
        check_eq("basic_cycles", CW'(cyc), CW'(8));
        check_eq("basic_frame_cnt", CW'(frame_cnt), CW'(1));
        check_eq("basic_one_start", CW'(start_cnt - s0), CW'(1));
        check_eq("basic_no_ferr", CW'(err_framing), CW'(0));

        // Backpressure
        drive_frame($urandom_range(0, 60000), 8'h80, 1'b1);
        respond($urandom_range(1, 40));
        drain(1'b1, cyc);
        check_eq("bp_cycles", CW'(cyc), CW'(16));
        check_eq("bp_frame_cnt", CW'(frame_cnt), CW'(2));

        // Framing: s_last on beat 3, missing on beat 7; err_clr held high so the beat-7 set must win
        err_clr = 1'b1;
        drive_frame($urandom_range(0, 60000), 8'h08, 1'b1);
        err_clr = 1'b0;
        check_eq("frm_err", CW'(err_framing), CW'(1));
        check_eq("frm_start", CW'(attn_start), CW'(1));
        respond($urandom_range(1, 40));
        drain(1'b0, cyc);
        check_eq("frm_frame_cnt", CW'(frame_cnt), CW'(3));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("frm_clr", CW'(err_framing), CW'(0));

        // Stray done while loading
        attn_done = 1'b1;
        for (int i = 0; i < L*E; i++) attn_out[i] = '1;
        step();
        attn_done = 1'b0;
        check_eq("stray_state", CW'(state_dbg), CW'(S_LOAD));
        check_eq("stray_m_valid", CW'(m_valid), CW'(0));
        check_eq("stray_busy", CW'(busy), CW'(0));

        // Timeout: core never answers
        m_ready = 1'b1;
        drive_frame(500, 8'h80, 1'b0);
        check_eq("to_start", CW'(attn_start), CW'(1));
        seen = 1'b0;
        repeat (64) begin
            step();
            if (m_valid) seen = 1'b1;
        end
        check_eq("to_not_yet", CW'(err_timeout), CW'(0));
        check_eq("to_still_wait", CW'(state_dbg), CW'(S_WAIT));
        step();
        check_eq("to_err", CW'(err_timeout), CW'(1));
        check_eq("to_s_ready", CW'(s_ready), CW'(1));
        check_eq("to_no_mvalid", CW'(seen | m_valid), CW'(0));
        check_eq("to_frame_cnt", CW'(frame_cnt), CW'(3));
        m_ready = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("to_clr", CW'(err_timeout), CW'(0));

        // Done coincides with the watchdog's last cycle
        drive_frame($urandom_range(0, 60000), 8'h80, 1'b1);
        respond(TO);
        check_eq("coin_state", CW'(state_dbg), CW'(S_DRAIN));
        check_eq("coin_no_to", CW'(err_timeout), CW'(0));
        drain(1'b0, cyc);
        check_eq("coin_frame_cnt", CW'(frame_cnt), CW'(4));

        // Reset in the middle of a drain
        drive_frame($urandom_range(0, 60000), 8'h80, 1'b1);
        respond(5);
        m_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        m_ready = 1'b0;
        #1;
        check_eq("mrst_m_valid", CW'(m_valid), CW'(0));
        check_eq("mrst_state", CW'(state_dbg), CW'(S_IDLE));
        exp_q.delete();
        step();
        rst = 1'b0;
        check_eq("mrst_idle_ready", CW'(s_ready), CW'(0));
        step();
        check_eq("mrst_ready", CW'(s_ready), CW'(1));
        check_eq("mrst_frame_cnt", CW'(frame_cnt), CW'(0));

        // Normal operation resumes after reset
        drive_frame($urandom_range(0, 60000), 8'h80, 1'b1);
        respond($urandom_range(1, 40));
        drain(1'b1, cyc);
        check_eq("post_cycles", CW'(cyc), CW'(16));
        check_eq("post_frame_cnt", CW'(frame_cnt), CW'(1));
        check_eq("post_q_empty", CW'(exp_q.size()), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
